// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches from imem, feeds the IF/ID register.
// Latency: one cycle from fetch accept to valid_id; one instruction per cycle sustained.
// Backpressure: stall_id holds IF/ID, one accepted word parks in a skid buffer, fetch pauses.
//
// Ports:
//   clock, reset_0            pipeline clock (rising edge), async active-low reset
//   stall_id                  decode cannot accept; IF/ID holds
//   flush, redirect_pc        EX redirect (branch/jump); target is word-aligned here
//   imem_addr/req/rdata/ready instruction memory fetch handshake (combinational response)
//   pc_if                     current fetch PC (same as imem_addr)
//   pc_id, instr_id, valid_id IF/ID pipeline register contents
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_0,
    input  logic        stall_id,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_if,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        valid_id
);

    // HOLD means the skid buffer is occupied; no separate occupancy flag is kept.
    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        accept;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = FETCH;
        end else begin
            case (state)
                FETCH:   if (accept && stall_id) state_nxt = HOLD;
                HOLD:    if (!stall_id)          state_nxt = FETCH;
                default: state_nxt = FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Gated by reset_0 so no request escapes while reset is held low.
        imem_req = reset_0 && (state == FETCH);
        accept   = imem_req && imem_ready;
    end

    assign imem_addr = pc;
    assign pc_if     = pc;

    // ------------------------------------------------------------------
    // PC, IF/ID register and skid buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            pc         <= RESET_PC;
            pc_id      <= 32'h0000_0000;
            instr_id   <= NOP_INSTR;
            valid_id   <= 1'b0;
            skid_pc    <= 32'h0000_0000;
            skid_instr <= NOP_INSTR;
        end else if (flush) begin
            // Redirect wins over stall and over any same-cycle memory response;
            // pc_id is left alone, only the valid/instr pair becomes a bubble.
            pc       <= redirect_pc & ~32'h0000_0003;
            instr_id <= NOP_INSTR;
            valid_id <= 1'b0;
        end else if (state == FETCH) begin
            if (accept) begin
                pc <= pc + 32'd4;
                if (stall_id) begin
                    skid_pc    <= pc;
                    skid_instr <= imem_rdata;
                end else begin
                    pc_id    <= pc;
                    instr_id <= imem_rdata;
                    valid_id <= 1'b1;
                end
            end else if (!stall_id) begin
                instr_id <= NOP_INSTR;
                valid_id <= 1'b0;
            end
        end else begin
            // HOLD: drain the parked word once decode frees up.
            if (!stall_id) begin
                pc_id    <= skid_pc;
                instr_id <= skid_instr;
                valid_id <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clock;
    logic        reset_0;
    logic        stall_id;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_if;
    logic [31:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset_0     (reset_0),
        .stall_id    (stall_id),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .pc_if       (pc_if),
        .pc_id       (pc_id),
        .instr_id    (instr_id),
        .valid_id    (valid_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents: word at address a is {16'h2000+n, n} with n = a/4 + 1.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [15:0] n;
        n = a[17:2] + 16'd1;
        return {16'h2000 + n, n};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: fetched-but-undelivered words live in a queue; a
    // fetch is only issued when nothing is waiting to be delivered.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    fetch_t      pend[$];
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_pc_id = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic        m_valid = 1'b0;

    initial begin
        fetch_t f;
        fetch_t d;
        bit     acc;
        forever begin
            @(posedge clock or negedge reset_0);
            if (!reset_0) begin
                m_pc = 32'h0; m_pc_id = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
                pend.delete();
            end else if (clock) begin
                acc = (pend.size() == 0) && imem_ready;
                if (flush) begin
                    pend.delete();
                    m_valid = 1'b0;
                    m_instr = 32'h0;
                    m_pc    = {redirect_pc[31:2], 2'b00};
                end else begin
                    f.pc    = m_pc;
                    f.instr = mem_word(m_pc);
                    if (acc) pend.push_back(f);
                    if (!stall_id) begin
                        if (pend.size() > 0) begin
                            d       = pend.pop_front();
                            m_pc_id = d.pc;
                            m_instr = d.instr;
                            m_valid = 1'b1;
                        end else begin
                            m_instr = 32'h0;
                            m_valid = 1'b0;
                        end
                    end
                    if (acc) m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            chk("imem_addr", imem_addr, m_pc);
            chk("pc_if",     pc_if,     m_pc);
            chk("imem_req",  {31'b0, imem_req}, {31'b0, reset_0 && (pend.size() == 0)});
            chk("valid_id",  {31'b0, valid_id}, {31'b0, m_valid});
            chk("instr_id",  instr_id,  m_instr);
            chk("pc_id",     pc_id,     m_pc_id);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                          input logic e_valid, input logic [31:0] e_addr);
        chk({tag, ".pc_id"},    pc_id,    e_pc);
        chk({tag, ".instr_id"}, instr_id, e_instr);
        chk({tag, ".valid_id"}, {31'b0, valid_id}, {31'b0, e_valid});
        chk({tag, ".imem_addr"}, imem_addr, e_addr);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------
    initial begin
        reset_0 = 1'b1; stall_id = 1'b0; flush = 1'b0;
        redirect_pc = 32'h0; imem_ready = 1'b1;
        #1 reset_0 = 1'b0;
        #1;
        chk_id("reset", 32'h0, 32'h0, 1'b0, 32'h0);
        chk("reset.imem_req", {31'b0, imem_req}, 32'h0);
        tick; tick;
        reset_0 = 1'b1;

        // Sequential fetch.
        tick; chk_id("seq0", 32'h0, 32'h2001_0001, 1'b1, 32'h4);
        tick; chk_id("seq1", 32'h4, 32'h2002_0002, 1'b1, 32'h8);

        // Memory wait at 0x8.
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick; chk_id("wait", 32'h4, 32'h0, 1'b0, 32'h8);
        end
        imem_ready = 1'b1;
        tick; chk_id("wait_done", 32'h8, 32'h2003_0003, 1'b1, 32'hC);

        // Stall while 0xC is accepted.
        stall_id = 1'b1;
        tick; chk_id("stall0", 32'h8, 32'h2003_0003, 1'b1, 32'h10);
        chk("stall0.imem_req", {31'b0, imem_req}, 32'h0);
        tick; chk_id("stall1", 32'h8, 32'h2003_0003, 1'b1, 32'h10);
        stall_id = 1'b0;
        tick; chk_id("drain", 32'hC, 32'h2004_0004, 1'b1, 32'h10);
        chk("drain.imem_req", {31'b0, imem_req}, 32'h1);
        tick; chk_id("resume", 32'h10, 32'h2005_0005, 1'b1, 32'h14);

        // Flush during HOLD with stall asserted.
        stall_id = 1'b1;
        tick; chk_id("hold", 32'h10, 32'h2005_0005, 1'b1, 32'h18);
        flush = 1'b1; redirect_pc = 32'h0000_0043;
        tick; chk_id("flush_hold", 32'h10, 32'h0, 1'b0, 32'h40);
        chk("flush_hold.imem_req", {31'b0, imem_req}, 32'h1);
        flush = 1'b0; stall_id = 1'b0;
        tick; chk_id("after_flush", 32'h40, 32'h2011_0011, 1'b1, 32'h44);

        // Redirect near the top of the address space; PC wraps.
        flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick; chk_id("flush_wrap", 32'h40, 32'h0, 1'b0, 32'hFFFF_FFFC);
        flush = 1'b0;
        tick; chk_id("wrap0", 32'hFFFF_FFFC, 32'h2000_0000, 1'b1, 32'h0);
        tick; chk_id("wrap1", 32'h0, 32'h2001_0001, 1'b1, 32'h4);

        // Asynchronous reset in the middle of a memory wait at 0x24.
        flush = 1'b1; redirect_pc = 32'h0000_0024;
        tick;
        flush = 1'b0; imem_ready = 1'b0;
        tick; chk_id("wait24", 32'h0, 32'h0, 1'b0, 32'h24);
        reset_0 = 1'b0;
        #1;
        chk_id("async_rst", 32'h0, 32'h0, 1'b0, 32'h0);
        chk("async_rst.imem_req", {31'b0, imem_req}, 32'h0);
        tick;
        reset_0 = 1'b1; imem_ready = 1'b1;
        tick; chk_id("restart", 32'h0, 32'h2001_0001, 1'b1, 32'h4);
        tick; chk_id("restart1", 32'h4, 32'h2002_0002, 1'b1, 32'h8);

        tick;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
